ex_mem_skid: RTL and testbench
==============================

# ex_mem_skid

EX/MEM pipeline stage of the RISC-V core, directly downstream of the ALU adder. It captures the ALU result plus the destination and memory-control fields of the executing instruction and presents them to the memory stage. A two-entry skid buffer decouples the two stages with a valid/ready handshake, so a memory-stage stall never needs a combinational ready path back into EX. Flush and stall are handled here.

## Interface
- DATA_W, 32, width of ALU result and store data
- RD_W, 5, register-file address width
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drop all held and incoming entries (branch/trap redirect)
- in_valid  in  1  EX has a completed instruction
- in_ready  out  1  stage can accept; registered, equals !skid_valid
- in_alu_result  in  DATA_W  ALU adder output
- in_store_data  in  DATA_W  rs2 value for stores
- in_rd_addr  in  RD_W  destination register
- in_rd_wen  in  1  instruction writes rd
- in_mem_ren  in  1  load
- in_mem_wen  in  1  store
- in_mem_funct3  in  3  load/store size and sign (funct3)
- out_valid  out  1  head entry valid
- out_ready  in  1  memory stage accepts head
- out_alu_result, out_store_data  out  DATA_W  head fields
- out_rd_addr  out  RD_W; out_rd_wen, out_mem_ren, out_mem_wen  out  1; out_mem_funct3  out  3
- fwd_valid  out  1  head writes a nonzero rd (EX_MEM_FWD_EN only)
- fwd_rd_addr  out  RD_W; fwd_data  out  DATA_W  bypass value

## Operation
- Storage: main register (head) and skid register, each with a valid bit; all fields flopped, no combinational path from in_* to out_*.
- Accept: in_fire = in_valid & in_ready & !flush.
- Drain: out_fire = out_valid & out_ready.
- Next state, priority order:
  - flush: main_valid<=0, skid_valid<=0; incoming beat discarded; data fields hold.
  - out_fire & skid_valid: main<=skid; skid<=in beat if in_fire (cannot occur, in_ready=0) else skid_valid<=0.
  - in_fire & (!main_valid | out_fire): main<=in beat.
  - in_fire & main_valid & !out_fire: skid<=in beat.
  - out_fire only: main_valid<=0.
- x0 squash: at capture, rd_wen stored as in_rd_wen & (in_rd_addr != 0).
- mem_ren and mem_wen both set is illegal; stored unchanged, no checking.
- Order is strict FIFO; no entry is duplicated or lost except by flush.

## Timing
- Reset: out_valid=0, all out_* data/control=0, in_ready=1, fwd_*=0.
- Latency: beat accepted in cycle N appears on out_* in cycle N+1 when main empty or draining.
- Full throughput 1 beat/cycle when out_ready held 1.
- out_ready low with main full: next accepted beat goes to skid; in_ready drops the following cycle.
- in_ready is a pure flop output; upstream may not depend on out_ready combinationally.
- out_* stable while out_valid & !out_ready (no change until drain or flush).
- Flush takes effect next cycle; out_valid=0 and in_ready=1 the cycle after flush.
- Reset mid-operation clears both entries immediately (async), data not preserved.

## Configuration
- EX_MEM_FWD_EN defined: fwd_valid = main_valid & out_rd_wen & !out_mem_ren; fwd_rd_addr = out_rd_addr; fwd_data = out_alu_result (combinational from head flops). Loads excluded since data not ready.
- Not defined: fwd_* ports present but tied to 0; no extra logic.

## Test plan
- Streaming: out_ready=1, 4 beats alu_result 0x1,0x2,0x3,0x4 back-to-back -> same values on out one cycle later each, in_ready stays 1.
- Backpressure: out_ready=0, send 0xA, 0xB -> out holds 0xA, in_ready=0 after second beat; raise out_ready -> 0xA then 0xB, in_ready returns to 1.
- Flush with both entries full and in_valid=1 (0xC) -> next cycle out_valid=0, in_ready=1, 0xC never appears.
- x0: in_rd_addr=0, in_rd_wen=1, result 0x55 -> out_rd_wen=0, fwd_valid=0.
- Forwarding (EX_MEM_FWD_EN): rd=5, result 0x1234, rd_wen=1 -> fwd_valid=1, fwd_rd_addr=5, fwd_data=0x1234; same with mem_ren=1 -> fwd_valid=0.
- Async reset asserted mid-stall with two entries -> out_valid=0 and in_ready=1 immediately, before next clk edge.

Source files
------------

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline stage with two-entry skid buffer
// Optional bypass outputs enabled by defining EX_MEM_FWD_EN.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_store_data,
    input  logic [RD_W-1:0]   in_rd_addr,
    input  logic              in_rd_wen,
    input  logic              in_mem_ren,
    input  logic              in_mem_wen,
    input  logic [2:0]        in_mem_funct3,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [RD_W-1:0]   out_rd_addr,
    output logic              out_rd_wen,
    output logic              out_mem_ren,
    output logic              out_mem_wen,
    output logic [2:0]        out_mem_funct3,
    output logic              fwd_valid,
    output logic [RD_W-1:0]   fwd_rd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] store_data;
        logic [RD_W-1:0]   rd_addr;
        logic              rd_wen;
        logic              mem_ren;
        logic              mem_wen;
        logic [2:0]        mem_funct3;
    } beat_t;

    beat_t in_beat;
    beat_t main_q;
    beat_t skid_q;
    logic  main_valid;
    logic  skid_valid;
    logic  in_fire;
    logic  out_fire;

    // Writes to x0 are squashed at capture so nothing downstream has to.
    always_comb begin
        in_beat            = '0;
        in_beat.alu_result = in_alu_result;
        in_beat.store_data = in_store_data;
        in_beat.rd_addr    = in_rd_addr;
        in_beat.rd_wen     = in_rd_wen & (in_rd_addr != '0);
        in_beat.mem_ren    = in_mem_ren;
        in_beat.mem_wen    = in_mem_wen;
        in_beat.mem_funct3 = in_mem_funct3;
    end

    assign in_ready = ~skid_valid;
    assign in_fire  = in_valid & in_ready & ~flush;
    assign out_fire = main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (out_fire && skid_valid) begin
            // in_ready is low whenever skid is occupied, so no new beat here
            main_q     <= skid_q;
            skid_valid <= 1'b0;
        end else if (in_fire && (!main_valid || out_fire)) begin
            main_q     <= in_beat;
            main_valid <= 1'b1;
        end else if (in_fire) begin
            skid_q     <= in_beat;
            skid_valid <= 1'b1;
        end else if (out_fire) begin
            main_valid <= 1'b0;
        end
    end

    assign out_valid      = main_valid;
    assign out_alu_result = main_q.alu_result;
    assign out_store_data = main_q.store_data;
    assign out_rd_addr    = main_q.rd_addr;
    assign out_rd_wen     = main_q.rd_wen;
    assign out_mem_ren    = main_q.mem_ren;
    assign out_mem_wen    = main_q.mem_wen;
    assign out_mem_funct3 = main_q.mem_funct3;

`ifdef EX_MEM_FWD_EN
    // Loads are excluded: their result is not known until the memory stage.
    assign fwd_valid   = main_valid & main_q.rd_wen & ~main_q.mem_ren;
    assign fwd_rd_addr = main_q.rd_addr;
    assign fwd_data    = main_q.alu_result;
`else
    assign fwd_valid   = 1'b0;
    assign fwd_rd_addr = '0;
    assign fwd_data    = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - self-checking bench for ex_mem_skid
module tb_ex_mem_skid;

`ifdef EX_MEM_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd_addr = '0;
    logic        in_rd_wen = 1'b0;
    logic        in_mem_ren = 1'b0;
    logic        in_mem_wen = 1'b0;
    logic [2:0]  in_mem_funct3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_alu_result;
    logic [31:0] out_store_data;
    logic [4:0]  out_rd_addr;
    logic        out_rd_wen;
    logic        out_mem_ren;
    logic        out_mem_wen;
    logic [2:0]  out_mem_funct3;
    logic        fwd_valid;
    logic [4:0]  fwd_rd_addr;
    logic [31:0] fwd_data;

    ex_mem_skid #(.DATA_W(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_store_data(in_store_data),
        .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen),
        .in_mem_ren(in_mem_ren), .in_mem_wen(in_mem_wen),
        .in_mem_funct3(in_mem_funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_store_data(out_store_data),
        .out_rd_addr(out_rd_addr), .out_rd_wen(out_rd_wen),
        .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
        .out_mem_funct3(out_mem_funct3),
        .fwd_valid(fwd_valid), .fwd_rd_addr(fwd_rd_addr), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
        logic        exp_rd_wen;
        logic        exp_fwd;
    } vec_t;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rd_wen;
        logic        ren;
        logic        wen;
        logic [2:0]  f3;
    } sb_t;

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        in_valid      = 1'b1;
        in_alu_result = v.alu;
        in_store_data = v.store;
        in_rd_addr    = v.rd;
        in_rd_wen     = v.rd_wen;
        in_mem_ren    = v.ren;
        in_mem_wen    = v.wen;
        in_mem_funct3 = v.f3;
    endtask

    task automatic drive_alu(input logic [31:0] alu);
        vec_t v;
        v = '{alu, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1};
        drive(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes are observed on the falling edge, where all
    // inputs and outputs are settled for the upcoming rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_beat", out_alu_result, 32'hFFFF_FFFF);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_alu", out_alu_result, e.alu);
                    chk("sb_store", out_store_data, e.store);
                    chk("sb_rd", {27'd0, out_rd_addr}, {27'd0, e.rd});
                    chk("sb_rd_wen", {31'd0, out_rd_wen}, {31'd0, e.rd_wen});
                    chk("sb_ctl", {29'd0, out_mem_ren, out_mem_wen, 1'b0} | {29'd0, 3'b0},
                        {29'd0, e.ren, e.wen, 1'b0});
                    chk("sb_f3", {29'd0, out_mem_funct3}, {29'd0, e.f3});
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back('{in_alu_result, in_store_data, in_rd_addr,
                               in_rd_wen && (in_rd_addr != 5'd0),
                               in_mem_ren, in_mem_wen, in_mem_funct3});
            end
        end
    end

    vec_t vecs[7];

    initial begin
        vecs[0] = '{32'h1,    32'h100,  5'd1,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
        vecs[1] = '{32'h2,    32'h200,  5'd2,  1'b1, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
        vecs[2] = '{32'h3,    32'hDEAD, 5'd3,  1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0};
        vecs[3] = '{32'h4,    32'h0,    5'd31, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1};
        vecs[4] = '{32'h55,   32'h0,    5'd0,  1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5] = '{32'h1234, 32'h0,    5'd5,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1};
        vecs[6] = '{32'h1234, 32'h0,    5'd5,  1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};

        #2;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_alu", out_alu_result, 32'd0);
        chk("reset_out_rd", {27'd0, out_rd_addr}, 32'd0);
        chk("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
        chk("reset_fwd_data", fwd_data, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Back-to-back streaming with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i]);
            step();
            chk("vec_out_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_in_ready", {31'd0, in_ready}, 32'd1);
            chk("vec_alu", out_alu_result, vecs[i].alu);
            chk("vec_store", out_store_data, vecs[i].store);
            chk("vec_rd", {27'd0, out_rd_addr}, {27'd0, vecs[i].rd});
            chk("vec_rd_wen", {31'd0, out_rd_wen}, {31'd0, vecs[i].exp_rd_wen});
            chk("vec_ren", {31'd0, out_mem_ren}, {31'd0, vecs[i].ren});
            chk("vec_wen", {31'd0, out_mem_wen}, {31'd0, vecs[i].wen});
            chk("vec_f3", {29'd0, out_mem_funct3}, {29'd0, vecs[i].f3});
            chk("vec_fwd_valid", {31'd0, fwd_valid}, {31'd0, vecs[i].exp_fwd & FWD});
            chk("vec_fwd_rd", {27'd0, fwd_rd_addr}, FWD ? {27'd0, vecs[i].rd} : 32'd0);
            chk("vec_fwd_data", fwd_data, FWD ? vecs[i].alu : 32'd0);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: second beat lands in skid, in_ready drops
        out_ready = 1'b0;
        drive_alu(32'hA);
        step();
        chk("bp_head_a", out_alu_result, 32'hA);
        chk("bp_in_ready_1", {31'd0, in_ready}, 32'd1);
        drive_alu(32'hB);
        step();
        in_valid = 1'b0;
        chk("bp_in_ready_0", {31'd0, in_ready}, 32'd0);
        chk("bp_hold_a", out_alu_result, 32'hA);
        step();
        step();
        chk("bp_stable_a", out_alu_result, 32'hA);
        chk("bp_stable_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp_head_b", out_alu_result, 32'hB);
        chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_valid}, 32'd0);

        // Flush with both entries full and a beat offered
        out_ready = 1'b0;
        drive_alu(32'hD);
        step();
        drive_alu(32'hE);
        step();
        chk("fl_full", {31'd0, in_ready}, 32'd0);
        drive_alu(32'hC);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", {31'd0, out_valid}, 32'd0);
        chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_c", {31'd0, out_valid}, 32'd0);
        end

        // Asynchronous reset mid-stall with two entries held
        out_ready = 1'b0;
        drive_alu(32'h11);
        step();
        drive_alu(32'h22);
        step();
        in_valid = 1'b0;
        chk("ar_full", {31'd0, in_ready}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, in_ready}, 32'd1);
        chk("ar_out_alu", out_alu_result, 32'd0);
        #4;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar_after", {31'd0, out_valid}, 32'd0);

        // Random streaming with random backpressure, checked by the scoreboard
        for (int i = 0; i < 200; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                vec_t v;
                v = '{$urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      3'($urandom_range(0, 7)), 1'b0, 1'b0};
                if (!(in_valid && !in_ready)) drive(v);
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("sb_empty_at_end", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
